// File: rtl/sink_ram_ctrl.sv
// sink_ram_ctrl: capture sequencer and single-port arbiter for the receive-side sink RAM.
// Optional feature macro SINK_CHECKSUM_EN adds a running per-frame checksum output.
module sink_ram_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned END_ADDR    = 255,
    parameter int unsigned SKIP_CYCLES = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_sink,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_grant,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done,
`ifdef SINK_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned WC_W   = ADDR_W + 1;
    localparam int unsigned SKIP_W = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SKIP    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        r_state;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic [WC_W-1:0]   r_word_count;
    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wren;
    logic              r_rd_grant;
    logic              r_rd_valid;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_sum;

    logic [1:0]        w_state_nxt;
    logic [SKIP_W-1:0] w_skip_nxt;
    logic [WC_W-1:0]   w_wc_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_wren_nxt;
    logic              w_grant_nxt;
    logic              w_wr;
    logic [DATA_W-1:0] w_sum_nxt;

    // Next-state, capture counters and per-cycle port arbitration (write beats read)
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        w_wc_nxt    = r_word_count;
        w_addr_nxt  = r_ram_address;
        w_data_nxt  = r_ram_data;
        w_wren_nxt  = 1'b0;
        w_grant_nxt = 1'b0;
        w_sum_nxt   = r_sum;
        w_wr        = (r_state == S_CAPTURE) && in_valid;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_sink) begin
                    w_state_nxt = S_SKIP;
                    w_skip_nxt  = '0;
                    w_wc_nxt    = '0;
                    w_sum_nxt   = '0;
                end
            end
            S_SKIP: begin
                if (r_skip_cnt == SKIP_W'(SKIP_CYCLES - 1)) begin
                    w_state_nxt = S_CAPTURE;
                    w_skip_nxt  = '0;
                end else begin
                    w_skip_nxt = r_skip_cnt + SKIP_W'(1);
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    w_wc_nxt = r_word_count + WC_W'(1);
                    if (r_word_count == WC_W'(END_ADDR)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_wr) begin
            w_addr_nxt = r_word_count[ADDR_W-1:0];
            w_data_nxt = data_in;
            w_wren_nxt = 1'b1;
            w_sum_nxt  = r_sum + data_in;
        end else if (rd_req) begin
            w_addr_nxt  = rd_addr;
            w_grant_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_skip_cnt    <= '0;
            r_word_count  <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wren    <= 1'b0;
            r_rd_grant    <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_sum         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_skip_cnt    <= w_skip_nxt;
            r_word_count  <= w_wc_nxt;
            r_ram_address <= w_addr_nxt;
            r_ram_data    <= w_data_nxt;
            r_ram_wren    <= w_wren_nxt;
            r_rd_grant    <= w_grant_nxt;
            r_rd_valid    <= r_rd_grant;
            r_busy        <= (w_state_nxt == S_SKIP) || (w_state_nxt == S_CAPTURE);
            r_done        <= (w_state_nxt == S_DONE);
            r_sum         <= w_sum_nxt;
        end
    end

    assign rd_grant    = r_rd_grant;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = ram_q;
    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign ram_wren    = r_ram_wren;
    assign busy        = r_busy;
    assign done        = r_done;
    assign word_count  = r_word_count;

`ifdef SINK_CHECKSUM_EN
    assign checksum = r_sum;
`else
    // Without the checksum output the accumulator has no load and is trimmed away
    logic w_sum_unused;
    assign w_sum_unused = ^r_sum;
`endif

endmodule
